// File: rtl/key_pkg.sv
// Shared definitions for the key gesture decoder: one-hot FSM states and
// the gesture event codes used by downstream event buffering.
package key_pkg;

  localparam logic [4:0] IDLE   = 5'b00001;
  localparam logic [4:0] PRESS1 = 5'b00010;
  localparam logic [4:0] HOLD   = 5'b00100;
  localparam logic [4:0] GAP    = 5'b01000;
  localparam logic [4:0] PRESS2 = 5'b10000;

  typedef enum logic [4:0] {
    StIdle   = IDLE,
    StPress1 = PRESS1,
    StHold   = HOLD,
    StGap    = GAP,
    StPress2 = PRESS2
  } state_e;

  localparam logic [1:0] EV_SINGLE = 2'd0;
  localparam logic [1:0] EV_DOUBLE = 2'd1;
  localparam logic [1:0] EV_LONG   = 2'd2;
  localparam logic [1:0] EV_REPEAT = 2'd3;

endpackage

// File: rtl/key_event_decoder.sv
// Classifies debounced key edges into single click, double click, long press
// and auto-repeat gestures; each gesture yields one registered one-cycle pulse.
module key_event_decoder
  import key_pkg::*;
#(
  parameter int unsigned CNT_W      = 26,
  parameter int unsigned LONG_CNT   = 25_000_000,
  parameter int unsigned DCLK_CNT   = 12_500_000,
  parameter int unsigned REPEAT_CNT = 5_000_000
) (
  input  logic Clk,
  input  logic Rst,
  input  logic key_flag,
  input  logic key_state,
  output logic single_click,
  output logic double_click,
  output logic long_press,
  output logic repeat_tick,
  output logic busy
);

  localparam logic [CNT_W-1:0] LongLast   = CNT_W'(LONG_CNT - 1);
  localparam logic [CNT_W-1:0] DclkLast   = CNT_W'(DCLK_CNT - 1);
  localparam logic [CNT_W-1:0] RepeatLast = CNT_W'(REPEAT_CNT - 1);

  state_e           r_state, w_state_d;
  logic [CNT_W-1:0] r_cnt, w_cnt_d;
  logic             r_single, r_double, r_long, r_repeat, r_busy;
  logic             w_single_d, w_double_d, w_long_d, w_repeat_d;
  logic             w_cnt_clr;
  logic             w_press_ev, w_rel_ev;

  assign w_press_ev = key_flag & ~key_state;
  assign w_rel_ev   = key_flag & key_state;

  // Key events are tested before terminal counts so an edge always wins.
  always_comb begin
    w_state_d  = r_state;
    w_single_d = 1'b0;
    w_double_d = 1'b0;
    w_long_d   = 1'b0;
    w_repeat_d = 1'b0;
    w_cnt_clr  = 1'b0;
    case (r_state)
      StIdle: begin
        if (w_press_ev) w_state_d = StPress1;
      end
      StPress1: begin
        if (w_rel_ev) begin
          w_state_d = StGap;
        end else if (r_cnt == LongLast) begin
          w_state_d = StHold;
          w_long_d  = 1'b1;
        end
      end
      StHold: begin
        if (w_rel_ev) begin
          w_state_d = StIdle;
        end else if (r_cnt == RepeatLast) begin
          w_repeat_d = 1'b1;
          w_cnt_clr  = 1'b1;
        end
      end
      StGap: begin
        if (w_press_ev) begin
          w_state_d = StPress2;
        end else if (r_cnt == DclkLast) begin
          w_state_d  = StIdle;
          w_single_d = 1'b1;
        end
      end
      StPress2: begin
        if (w_rel_ev) begin
          w_state_d  = StIdle;
          w_double_d = 1'b1;
        end
      end
      default: w_state_d = StIdle;
    endcase
  end

  always_comb begin
    w_cnt_d = r_cnt;
    if (w_state_d != r_state || w_cnt_clr) begin
      w_cnt_d = '0;
    end else if (r_state == StPress1 || r_state == StHold || r_state == StGap) begin
      w_cnt_d = r_cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      r_state  <= StIdle;
      r_cnt    <= '0;
      r_single <= 1'b0;
      r_double <= 1'b0;
      r_long   <= 1'b0;
      r_repeat <= 1'b0;
      r_busy   <= 1'b0;
    end else begin
      r_state  <= w_state_d;
      r_cnt    <= w_cnt_d;
      r_single <= w_single_d;
      r_double <= w_double_d;
      r_long   <= w_long_d;
      r_repeat <= w_repeat_d;
      r_busy   <= (w_state_d != StIdle);
    end
  end

  assign single_click = r_single;
  assign double_click = r_double;
  assign long_press   = r_long;
  assign repeat_tick  = r_repeat;
  assign busy         = r_busy;

endmodule

// File: tb/tb_key_event_decoder.sv
// Scoreboard bench for key_event_decoder: a timestamp-based gesture model
// queues expected pulses and busy levels; a monitor compares every cycle.
module tb_key_event_decoder;

  localparam int unsigned L = 20;
  localparam int unsigned D = 10;
  localparam int unsigned R = 5;

  localparam int PH_IDLE   = 0;
  localparam int PH_FIRST  = 1;
  localparam int PH_LONG   = 2;
  localparam int PH_GAP    = 3;
  localparam int PH_SECOND = 4;

  localparam int P_NONE   = 0;
  localparam int P_SINGLE = 1;
  localparam int P_DOUBLE = 2;
  localparam int P_LONG   = 3;
  localparam int P_REPEAT = 4;

  logic Clk = 1'b0;
  logic Rst = 1'b1;
  logic key_flag = 1'b0;
  logic key_state = 1'b1;
  logic single_click, double_click, long_press, repeat_tick, busy;

  key_event_decoder #(
    .CNT_W     (26),
    .LONG_CNT  (L),
    .DCLK_CNT  (D),
    .REPEAT_CNT(R)
  ) dut (
    .Clk         (Clk),
    .Rst         (Rst),
    .key_flag    (key_flag),
    .key_state   (key_state),
    .single_click(single_click),
    .double_click(double_click),
    .long_press  (long_press),
    .repeat_tick (repeat_tick),
    .busy        (busy)
  );

  always #5 Clk = ~Clk;

  int cyc = 0;
  always @(posedge Clk) cyc <= cyc + 1;

  typedef struct {
    int cyc;
    int val;
  } exp_t;

  exp_t pulse_q[$];
  exp_t busy_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // Gesture model: phase plus the cycle at which the current timing window began.
  int m_phase = PH_IDLE;
  int m_start = 0;

  task automatic drive(input logic rst, input logic flag, input logic st);
    int code;
    bit pr, rl;
    @(negedge Clk);
    Rst = rst;
    key_flag = flag;
    key_state = st;
    pr = flag && !st;
    rl = flag && st;
    code = P_NONE;
    if (rst) begin
      m_phase = PH_IDLE;
    end else begin
      case (m_phase)
        PH_IDLE: if (pr) begin m_phase = PH_FIRST; m_start = cyc; end
        PH_FIRST: begin
          if (rl) begin
            m_phase = PH_GAP; m_start = cyc;
          end else if (cyc == m_start + int'(L)) begin
            m_phase = PH_LONG; m_start = cyc; code = P_LONG;
          end
        end
        PH_LONG: begin
          if (rl) m_phase = PH_IDLE;
          else if (cyc == m_start + int'(R)) begin m_start = cyc; code = P_REPEAT; end
        end
        PH_GAP: begin
          if (pr) m_phase = PH_SECOND;
          else if (cyc == m_start + int'(D)) begin m_phase = PH_IDLE; code = P_SINGLE; end
        end
        default: if (rl) begin m_phase = PH_IDLE; code = P_DOUBLE; end
      endcase
    end
    if (code != P_NONE) pulse_q.push_back('{cyc: cyc + 1, val: code});
    busy_q.push_back('{cyc: cyc + 1, val: (m_phase != PH_IDLE) ? 1 : 0});
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 1'($urandom_range(0, 1)));
  endtask

  task automatic press();
    drive(1'b0, 1'b1, 1'b0);
  endtask

  task automatic release_key();
    drive(1'b0, 1'b1, 1'b1);
  endtask

  task automatic check_cycle();
    int   obs;
    int   n_hi;
    exp_t e;
    n_hi = int'(single_click) + int'(double_click) + int'(long_press) + int'(repeat_tick);
    obs = single_click ? P_SINGLE : double_click ? P_DOUBLE :
          long_press ? P_LONG : repeat_tick ? P_REPEAT : P_NONE;
    n_checks++;
    if (n_hi > 1) begin
      n_fail++;
      $display("FAIL onehot cycle %0d: %0d pulses high, required at most 1", cyc, n_hi);
    end
    while (pulse_q.size() > 0 && pulse_q[0].cyc < cyc) begin
      e = pulse_q.pop_front();
      n_checks++;
      n_fail++;
      $display("FAIL pulse_missed cycle %0d: code 0, required code %0d", e.cyc, e.val);
    end
    if (pulse_q.size() > 0 && pulse_q[0].cyc == cyc) begin
      e = pulse_q.pop_front();
      n_checks++;
      if (obs != e.val) begin
        n_fail++;
        $display("FAIL pulse cycle %0d: code %0d, required %0d", cyc, obs, e.val);
      end
    end else if (obs != P_NONE) begin
      n_checks++;
      n_fail++;
      $display("FAIL pulse_unexpected cycle %0d: code %0d, required none", cyc, obs);
    end
    while (busy_q.size() > 0 && busy_q[0].cyc < cyc) void'(busy_q.pop_front());
    if (busy_q.size() > 0 && busy_q[0].cyc == cyc) begin
      e = busy_q.pop_front();
      n_checks++;
      if (int'(busy) != e.val) begin
        n_fail++;
        $display("FAIL busy cycle %0d: %0d, required %0d", cyc, busy, e.val);
      end
    end
  endtask

  initial begin
    forever begin
      @(posedge Clk);
      #1;
      check_cycle();
    end
  end

  initial begin
    for (int i = 0; i < 3; i++) drive(1'b1, 1'b0, 1'b1);
    idle(5);

    // Single click
    press(); idle(4); release_key(); idle(20);
    // Double click
    press(); idle(4); release_key(); idle(4); press(); idle(3); release_key(); idle(20);
    // Long press with repeats; release lands on the repeat terminal
    press(); idle(39); release_key(); idle(20);
    // Second press exactly at the gap terminal
    press(); idle(4); release_key(); idle(9); press(); idle(2); release_key(); idle(20);
    // Release at the long-press terminal, then single click times out
    press(); idle(19); release_key(); idle(20);
    // Reset mid-hold
    press(); idle(24); drive(1'b1, 1'b0, 1'b0); idle(4); release_key(); idle(20);
    // Stray release in idle, key_flag during reset
    release_key(); idle(3); drive(1'b1, 1'b1, 1'b0); idle(10);
    // Back-to-back gestures
    press(); release_key(); press(); release_key(); press(); idle(15);

    for (int g = 0; g < 120; g++) begin
      press();
      idle($urandom_range(0, 32));
      release_key();
      idle($urandom_range(0, 14));
      if ($urandom_range(0, 9) == 0) drive(1'b1, 1'($urandom_range(0, 1)), 1'b0);
    end
    for (int i = 0; i < 600; i++) begin
      drive(1'($urandom_range(0, 99) == 0), 1'($urandom_range(0, 5) == 0),
            1'($urandom_range(0, 1)));
    end
    idle(40);

    @(negedge Clk);
    n_checks++;
    if (pulse_q.size() != 0) begin
      n_fail++;
      $display("FAIL pulse_leftover: %0d expected pulses never seen, required 0", pulse_q.size());
    end
    $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
    $finish;
  end

endmodule

// File: doc/key_event_decoder.md
Name: key_event_decoder

Overview:
- Sits directly downstream of the debounced key filter. Consumes its one-cycle `key_flag` pulse and its `key_state` level (0 = pressed, 1 = released).
- Classifies the key gesture and emits one registered pulse per gesture: single click, double click, long press, or auto-repeat tick while the key is held.
- Its outputs drive the control/configuration logic directly, e.g. mode stepping on the NoC demo board.

Parameters:
- `CNT_W`, 26: width of the internal timing counter.
- `LONG_CNT`, 25_000_000: cycles the key must stay pressed before a long press fires (0.5 s at 50 MHz).
- `DCLK_CNT`, 12_500_000: maximum gap, in cycles, between the first release and the second press for a double click.
- `REPEAT_CNT`, 5_000_000: period, in cycles, of `repeat_tick` after a long press.
- Constraint: each count is ≥ 2 and < 2^`CNT_W`.

Ports:
- `Clk`  in  1  system clock, 50 MHz
- `Rst`  in  1  synchronous, active-high reset
- `key_flag`  in  1  one-cycle pulse marking a debounced key edge
- `key_state`  in  1  debounced level, valid when `key_flag`=1 (0 = press, 1 = release)
- `single_click`  out  1  one-cycle pulse
- `double_click`  out  1  one-cycle pulse
- `long_press`  out  1  one-cycle pulse
- `repeat_tick`  out  1  one-cycle pulse
- `busy`  out  1  high whenever the FSM is not in IDLE

Behaviour:
- **Events:**
  - `press_ev` = `key_flag` & !`key_state`.
  - `rel_ev` = `key_flag` & `key_state`.
  - Any event that is not meaningful in the current state is ignored, e.g. a release while in IDLE.
- **Reset:** one clock with `Rst`=1 at any point gives the following on the next cycle:
  - state = IDLE, cnt = 0;
  - all four pulse outputs = 0;
  - `busy` = 0.
- **Counter rules:**
  - `cnt` is cleared on every state change.
  - Otherwise it increments by 1 each cycle while in PRESS1, HOLD or GAP.
  - It never wraps, because each terminal compare clears or leaves the state first.
- **States:** one-hot, 5 bits.
  - IDLE: on `press_ev`, go to PRESS1.
  - PRESS1:
    - `rel_ev` → GAP;
    - else if cnt == `LONG_CNT`-1 → HOLD and assert `long_press`.
  - HOLD:
    - `rel_ev` → IDLE, with no click emitted;
    - else if cnt == `REPEAT_CNT`-1 → assert `repeat_tick`, clear cnt, stay in HOLD.
  - GAP:
    - `press_ev` → PRESS2;
    - else if cnt == `DCLK_CNT`-1 → assert `single_click`, go to IDLE.
  - PRESS2: no timeout; on `rel_ev`, assert `double_click` and go to IDLE.
  - Any illegal encoding → IDLE, with outputs cleared.
- **Priority:** a key event always wins over a same-cycle terminal count.
  - Release at the long threshold: no `long_press`.
  - Press at the gap timeout: no `single_click`.
  - Release at the repeat terminal: no `repeat_tick`.
- **Outputs:**
  - All outputs are registered; each pulse is high for exactly one cycle.
  - At most one pulse is high in any cycle.
  - `busy` is registered and equals (next state ≠ IDLE).
- **Latency:** with the triggering event accepted in cycle t:
  - `long_press` is high in cycle t+`LONG_CNT`+1, where t is the press cycle.
  - The first `repeat_tick` comes `REPEAT_CNT` cycles after `long_press`; later ticks follow every `REPEAT_CNT` cycles.
  - `single_click` is high in cycle t+`DCLK_CNT`+1, where t is the release cycle.
  - `double_click` is high in cycle t+1, where t is the second release cycle.
- **Back-to-back gestures:** a press in the cycle after returning to IDLE is accepted normally.

Decomposition:
- Package `key_pkg` holds:
  - the one-hot state localparams (IDLE, PRESS1, HOLD, GAP, PRESS2);
  - the 2-bit event code constants (`EV_SINGLE`, `EV_DOUBLE`, `EV_LONG`, `EV_REPEAT`), for later use by an event FIFO.
- No sub-module. A single FSM plus one counter is natural. `key_filter` is instantiated beside this block at top level, not inside it.

Test Plan:
All scenarios use `LONG_CNT`=20, `DCLK_CNT`=10, `REPEAT_CNT`=5, and drive `key_flag`/`key_state` directly.
1. Press at cycle 100, release at 105 → `single_click` high only in cycle 116; no other pulses; `busy` falls in 116.
2. Press 100, release 105, press 110, release 114 → `double_click` in cycle 115; `single_click` never fires.
3. Press 100, held until release at 140:
   - `long_press` in 121;
   - `repeat_tick` in 126, 131 and 136;
   - the release coincides with the repeat terminal count, so there is no tick at 141 and no click;
   - `busy` = 0 in 141.
4. Release at 105, second press exactly at the gap terminal (cycle 115), release 118 → `double_click` in 119; no `single_click`. Also: release in PRESS1 at cnt == 19 → GAP entered, no `long_press`.
5. Press 100, `Rst` high in cycle 125 (mid-HOLD), release 130 → all outputs 0 and `busy`=0 from 126 onward; the release produces nothing.
6. Stray release event in IDLE, and a `key_flag` pulse during reset → no pulses; `busy` stays 0.
